ethernet_receive_data: RTL and testbench



---
 rtl/ethernet_receive_data.sv | 198 +++++++++++++++++++
 tb/tb_ethernet_receive_data.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_receive_data.sv
// MII receive deserialiser: strips preamble/SFD, skips a fixed header and writes payload bytes to a byte RAM.
// Optional FCS checking is enabled by defining ETH_RX_CRC_CHECK_EN.
module ethernet_receive_data #(
  parameter int unsigned HDR_LEN   = 42,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MIN_PRE   = 8,
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic              ETH_RX_CLK,
  input  logic              rst_n,
  input  logic [3:0]        ETH_RX_DATA,
  input  logic              ETH_RX_DV,
  input  logic              ETH_RX_ER,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] data_adr,
  output logic              wr_en,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [ADDR_W-1:0] payload_len
);

  localparam int unsigned WIN = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DONE} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [7:0]          pre_cnt_q, pre_cnt_d;
  logic                phase_q, phase_d;
  logic [3:0]          low_q, low_d;
  logic [15:0]         byte_cnt_q, byte_cnt_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                wr_en_q, wr_en_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_ok_q, frame_ok_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                crc_good;
  logic [31:0]         cnt_ext;
  logic [31:0]         rel_idx;
  logic [31:0]         len_raw;

  assign cnt_ext = 32'(byte_cnt_q);
  assign rel_idx = cnt_ext - HDR_LEN;
  assign len_raw = cnt_ext - HDR_LEN - 32'd4;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'h0, n};
    for (int unsigned i = 0; i < 4; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_good = (crc_q == 32'hDEBB_20E3);

  always_comb begin
    crc_d = crc_q;
    if (state_q == PREAMBLE && ETH_RX_DV && ETH_RX_DATA == 4'hD) begin
      crc_d = '1;
    end else if (state_q == DATA && ETH_RX_DV) begin
      crc_d = crc_nib(crc_q, ETH_RX_DATA);
    end
  end

  always_ff @(posedge ETH_RX_CLK or negedge rst_n) begin
    if (!rst_n) crc_q <= '1;
    else        crc_q <= crc_d;
  end
`else
  assign crc_good = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q | ~ETH_RX_DV;
    pre_cnt_d    = pre_cnt_q;
    phase_d      = phase_q;
    low_d        = low_q;
    byte_cnt_d   = byte_cnt_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    data_d       = data_q;
    adr_d        = adr_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    len_d        = len_q;

    unique case (state_q)
      IDLE: begin
        // armed only goes high once DV has been seen low after reset
        if (armed_q && ETH_RX_DV) begin
          if (ETH_RX_DATA == 4'h5) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!ETH_RX_DV) begin
          state_d = IDLE;
        end else if (ETH_RX_DATA == 4'h5) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (ETH_RX_DATA == 4'hD && 32'(pre_cnt_q) >= MIN_PRE) begin
          state_d    = DATA;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (ETH_RX_DV) begin
          if (ETH_RX_ER) err_d = 1'b1;
          if (!phase_q) begin
            low_d   = ETH_RX_DATA;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 16'd1;
            if (cnt_ext >= HDR_LEN) begin
              if (rel_idx < WIN) begin
                wr_en_d = 1'b1;
                data_d  = {ETH_RX_DATA, low_q};
                adr_d   = rel_idx[ADDR_W-1:0];
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end else begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          frame_ok_d   = ~err_q & ~ovf_q & ~phase_q & (cnt_ext >= MIN_FRAME) & crc_good;
          if (cnt_ext <= HDR_LEN + 4) len_d = '0;
          else if (len_raw >= WIN)    len_d = '1;
          else                        len_d = len_raw[ADDR_W-1:0];
        end
      end
      DONE: state_d = IDLE;
      DROP: if (!ETH_RX_DV) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ETH_RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      pre_cnt_q    <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
      byte_cnt_q   <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      data_q       <= '0;
      adr_q        <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      pre_cnt_q    <= pre_cnt_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      byte_cnt_q   <= byte_cnt_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      data_q       <= data_d;
      adr_q        <= adr_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      len_q        <= len_d;
    end
  end

  assign data        = data_q;
  assign data_adr    = adr_q;
  assign wr_en       = wr_en_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign payload_len = len_q;

endmodule

// File: tb/tb_ethernet_receive_data.sv
// Scoreboard bench for ethernet_receive_data: stimulus pushes expected writes/status, a negedge monitor pops and compares.
module tb_ethernet_receive_data;

`ifdef ETH_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  data;
  logic [10:0] data_adr;
  logic        wr_en;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] payload_len;

  ethernet_receive_data #(.HDR_LEN(42), .ADDR_W(11), .MIN_PRE(8), .MIN_FRAME(64)) dut (
    .ETH_RX_CLK (clk),
    .rst_n      (rst_n),
    .ETH_RX_DATA(rx_data),
    .ETH_RX_DV  (rx_dv),
    .ETH_RX_ER  (rx_er),
    .data       (data),
    .data_adr   (data_adr),
    .wr_en      (wr_en),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .payload_len(payload_len)
  );

  always #20 clk = ~clk;

  typedef struct { logic [10:0] adr; logic [7:0] dat; } wr_t;
  typedef struct { logic ok; int len; } st_t;

  wr_t  wq[$];
  st_t  sq[$];
  wr_t  mw;
  st_t  ms;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] fb [0:2199];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: adr %0d data %0h, none expected", data_adr, data);
      end else begin
        mw = wq.pop_front();
        chk("wr_adr", 32'(data_adr), 32'(mw.adr));
        chk("wr_data", 32'(data), 32'(mw.dat));
      end
    end
    if (frame_done) begin
      if (sq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame_done: ok %0d len %0d, none expected", frame_ok, payload_len);
      end else begin
        ms = sq.pop_front();
        chk("frame_ok", 32'(frame_ok), 32'(ms.ok));
        if (ms.len >= 0) chk("payload_len", 32'(payload_len), ms.len);
      end
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [3:0] nib);
    @(posedge clk);
    #1;
    rx_dv = dv; rx_er = er; rx_data = nib;
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n total bytes including a valid FCS; optional single-bit corruption after FCS
  task automatic build(input int n, input int flip);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) fb[i] = 8'((i * 7 + 3) ^ (i >> 3));
    f = fcs_of(n - 4);
    fb[n-4] = f[7:0]; fb[n-3] = f[15:8]; fb[n-2] = f[23:16]; fb[n-1] = f[31:24];
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h10;
  endtask

  task automatic send(input int pre5, input bit bad_pre, input int n, input int er_byte,
                      input bit dribble, input bit expect_out, input bit exp_ok, input int exp_len,
                      input int ifg);
    wr_t w;
    st_t s;
    if (expect_out) begin
      for (int i = 42; i < n; i++) begin
        if (i - 42 < 2048) begin
          w.adr = 11'(i - 42); w.dat = fb[i];
          wq.push_back(w);
        end
      end
      s.ok = exp_ok; s.len = exp_len;
      sq.push_back(s);
    end
    for (int i = 0; i < pre5; i++) drive(1'b1, 1'b0, 4'h5);
    if (bad_pre) begin
      drive(1'b1, 1'b0, 4'hA);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h5);
    end
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == er_byte, fb[i][3:0]);
      drive(1'b1, i == er_byte, fb[i][7:4]);
    end
    if (dribble) drive(1'b1, 1'b0, 4'h3);
    for (int i = 0; i < ifg; i++) drive(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #(40 * 60000);
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 4'h0;
    @(negedge clk);
    chk("rst_data", 32'(data), 0);
    chk("rst_adr", 32'(data_adr), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_ok", 32'(frame_ok), 0);
    chk("rst_payload_len", 32'(payload_len), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 4'h0);

    // good frame
    build(64, -1);
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, 1'b1, 18, 24);
    // corrupted payload byte: CRC-dependent status
    build(64, 50);
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, !CRC_ON, 18, 24);
    // runt: 36 data + 4 FCS
    build(40, -1);
    send(15, 1'b0, 40, -1, 1'b0, 1'b1, 1'b0, 0, 24);
    // receive error in byte 45
    build(64, -1);
    send(15, 1'b0, 64, 45, 1'b0, 1'b1, 1'b0, 18, 24);
    // dribble nibble
    send(15, 1'b0, 64, -1, 1'b1, 1'b1, 1'b0, 18, 24);
    // short preamble, broken preamble, then a good frame
    send(4, 1'b0, 64, -1, 1'b0, 1'b0, 1'b0, 0, 24);
    send(6, 1'b1, 64, -1, 1'b0, 1'b0, 1'b0, 0, 24);
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, 1'b1, 18, 24);
    // oversize: writes stop at 2047
    build(2100, -1);
    send(15, 1'b0, 2100, -1, 1'b0, 1'b1, 1'b0, -1, 24);

    // reset during DATA at byte 50; byte 49's write is cut off by the reset
    build(64, -1);
    for (int i = 42; i < 49; i++) begin
      w.adr = 11'(i - 42); w.dat = fb[i];
      wq.push_back(w);
    end
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, fb[i][3:0]);
      drive(1'b1, 1'b0, fb[i][7:4]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0; rx_data = fb[50][3:0];
    @(negedge clk);
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_data", 32'(data), 0);
    chk("midrst_adr", 32'(data_adr), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_frame_ok", 32'(frame_ok), 0);
    chk("midrst_payload_len", 32'(payload_len), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 51; i < 64; i++) begin
      drive(1'b1, 1'b0, fb[i][3:0]);
      drive(1'b1, 1'b0, fb[i][7:4]);
    end
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b0, 4'h0);
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, 1'b1, 18, 24);
    // back-to-back good frames
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, 1'b1, 18, 24);
    send(15, 1'b0, 64, -1, 1'b0, 1'b1, 1'b1, 18, 24);

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("writes_outstanding", 32'(wq.size()), 0);
    chk("status_outstanding", 32'(sq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
